// File: rtl/program_memory_if.sv
// Byte-wide load stream plus CPU memory port shared between the program
// loader/CPU side (master) and the program memory (slave).
interface program_memory_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          read;
  logic          write;
  logic [AW-1:0] address;
  logic [DW-1:0] memoryIn;
  logic [DW-1:0] memoryOut;

  modport master (
    output load_valid, load_data, load_last,
    output read, write, address, memoryIn,
    input  load_ready, memoryOut
  );

  modport slave (
    input  load_valid, load_data, load_last,
    input  read, write, address, memoryIn,
    output load_ready, memoryOut
  );
endinterface

// File: rtl/program_memory.sv
// 16x8 program/data memory: streams a program in during LOAD, then holds the
// CPU in reset until loading completes and serves its read/write port in RUN.
module program_memory #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          reload,
  output logic          cpu_run,
  output logic [AW:0]   load_count,
  program_memory_if.slave bus
);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] load_ptr_q, load_ptr_d;
  logic [AW:0]   load_count_q, load_count_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          load_accept;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  assign load_accept = (state_q == LOAD) && bus.load_valid;
  assign load_count  = load_count_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= LOAD;
      load_ptr_q   <= '0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      load_ptr_q   <= load_ptr_d;
      load_count_q <= load_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    load_ptr_d   = load_ptr_q;
    load_count_d = load_count_q;
    case (state_q)
      LOAD: begin
        if (load_accept) begin
          load_count_d = load_count_q + 1'b1;
          // The pointer saturates at the last word; LOAD always exits there.
          if (load_ptr_q != LAST_PTR) begin
            load_ptr_d = load_ptr_q + 1'b1;
          end
          if ((load_ptr_q == LAST_PTR) || bus.load_last) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (reload) begin
          state_d      = LOAD;
          load_ptr_d   = '0;
          load_count_d = '0;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_comb begin
    bus.load_ready = (state_q == LOAD);
    cpu_run        = (state_q == RUN);
    bus.memoryOut  = '0;
    mem_we         = 1'b0;
    mem_waddr      = load_ptr_q;
    mem_wdata      = bus.load_data;
    if (state_q == LOAD) begin
      mem_we = load_accept;
    end else begin
      mem_we    = bus.write;
      mem_waddr = bus.address;
      mem_wdata = bus.memoryIn;
      if (bus.read) begin
        bus.memoryOut = mem_q[bus.address];
      end
    end
  end

  // The array has no reset so a mid-run reset preserves the loaded program.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule
